// File: rtl/game_pkg.sv
// Shared keyboard constants and byte-FSM state type for the game input path.
// Arrow-key scan codes are only consumed when ARROW_KEYS_EN is defined.
package game_pkg;

  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_W       = 8'h1D;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_ESC     = 8'h76;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_UP      = 8'h75;
  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_EXT     = 2'd1,
    KS_BRK     = 2'd2,
    KS_EXT_BRK = 2'd3
  } kbd_state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PREFIX_EXT) || (b == PREFIX_BRK);
  endfunction

endpackage

// File: rtl/kbd_scan_fsm.sv
// PS/2 set-2 byte parser: folds E0/F0 prefixes into one code strobe per key
// event, and drops a stalled prefix after PREFIX_TIMEOUT_US with no byte.
module kbd_scan_fsm
  import game_pkg::*;
#(
  parameter int CLK_HZ            = 65_000_000,
  parameter int PREFIX_TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       is_ext,
  output logic       is_break
);

  localparam int LIMIT = CLK_HZ / 1_000_000 * PREFIX_TIMEOUT_US;
  localparam int CNT_W = $clog2(LIMIT + 1);

  kbd_state_t       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= KS_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (rx_valid)                  r_cnt <= '0;
      else if (r_cnt != CNT_W'(LIMIT)) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Code strobe is combinational so the top can register its response in the
  // same cycle the final byte arrives.
  always_comb begin
    w_next     = r_state;
    code_valid = 1'b0;
    code       = rx_data;
    is_ext     = (r_state == KS_EXT) || (r_state == KS_EXT_BRK);
    is_break   = (r_state == KS_BRK) || (r_state == KS_EXT_BRK);
    if (rx_valid) begin
      case (r_state)
        KS_IDLE: begin
          if (rx_data == PREFIX_EXT)      w_next = KS_EXT;
          else if (rx_data == PREFIX_BRK) w_next = KS_BRK;
          else                            code_valid = 1'b1;
        end
        KS_EXT: begin
          if (rx_data == PREFIX_BRK) w_next = KS_EXT_BRK;
          else if (rx_data != PREFIX_EXT) begin
            w_next     = KS_IDLE;
            code_valid = 1'b1;
          end
        end
        KS_BRK: begin
          w_next     = KS_IDLE;
          code_valid = !is_prefix(rx_data);
        end
        KS_EXT_BRK: begin
          w_next     = KS_IDLE;
          code_valid = 1'b1;
        end
      endcase
    end else if (r_state != KS_IDLE && r_cnt == CNT_W'(LIMIT)) begin
      w_next = KS_IDLE;
    end
  end

endmodule

// File: rtl/char_input_decoder.sv
// Turns parsed key events into held step levels (with left/right last-pressed
// arbitration) and start/pause strobes. ARROW_KEYS_EN adds E0-arrow keys.
module char_input_decoder
  import game_pkg::*;
#(
  parameter int CLK_HZ            = 65_000_000,
  parameter int PREFIX_TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [1:0] game_active,
  output logic       stepleft,
  output logic       stepright,
  output logic       stepjump,
  output logic       key_start,
  output logic       key_pause
);

  logic       w_code_valid, w_is_ext, w_is_break;
  logic [7:0] w_code;

  kbd_scan_fsm #(.CLK_HZ(CLK_HZ), .PREFIX_TIMEOUT_US(PREFIX_TIMEOUT_US)) u_fsm (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .code_valid(w_code_valid), .code(w_code), .is_ext(w_is_ext), .is_break(w_is_break)
  );

  logic r_a, r_d, r_w, r_sp, r_last_r;
  logic w_a, w_d, w_w, w_sp, w_last_r;
  logic w_mk, w_held_l, w_held_r, w_held_j;
  logic r_stepleft, r_stepright, r_stepjump, r_key_start, r_key_pause;
`ifdef ARROW_KEYS_EN
  logic r_al, r_ar, r_aj, w_al, w_ar, w_aj;
`endif

  assign w_mk = !w_is_break;

  always_comb begin
    w_a      = r_a;
    w_d      = r_d;
    w_w      = r_w;
    w_sp     = r_sp;
    w_last_r = r_last_r;
    if (w_code_valid && !w_is_ext) begin
      case (w_code)
        SC_A:     begin w_a = w_mk; if (w_mk) w_last_r = 1'b0; end
        SC_D:     begin w_d = w_mk; if (w_mk) w_last_r = 1'b1; end
        SC_W:     w_w  = w_mk;
        SC_SPACE: w_sp = w_mk;
        default:  ;
      endcase
    end
`ifdef ARROW_KEYS_EN
    w_al = r_al;
    w_ar = r_ar;
    w_aj = r_aj;
    if (w_code_valid && w_is_ext) begin
      case (w_code)
        SC_LEFT:  begin w_al = w_mk; if (w_mk) w_last_r = 1'b0; end
        SC_RIGHT: begin w_ar = w_mk; if (w_mk) w_last_r = 1'b1; end
        SC_UP:    w_aj = w_mk;
        default:  ;
      endcase
    end
    w_held_l = w_a | w_al;
    w_held_r = w_d | w_ar;
    w_held_j = w_w | w_sp | w_aj;
`else
    w_held_l = w_a;
    w_held_r = w_d;
    w_held_j = w_w | w_sp;
`endif
  end

  // Outputs are registered from next-state flags so a key event shows up one
  // cycle after its final byte, not two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= 1'b0;
      r_d         <= 1'b0;
      r_w         <= 1'b0;
      r_sp        <= 1'b0;
      r_last_r    <= 1'b0;
      r_stepleft  <= 1'b0;
      r_stepright <= 1'b0;
      r_stepjump  <= 1'b0;
      r_key_start <= 1'b0;
      r_key_pause <= 1'b0;
    end else begin
      r_a         <= w_a;
      r_d         <= w_d;
      r_w         <= w_w;
      r_sp        <= w_sp;
      r_last_r    <= w_last_r;
      r_stepleft  <= (game_active == 2'd1) && w_held_l && (!w_held_r || !w_last_r);
      r_stepright <= (game_active == 2'd1) && w_held_r && (!w_held_l ||  w_last_r);
      r_stepjump  <= (game_active == 2'd1) && w_held_j;
      r_key_start <= w_code_valid && !w_is_ext && w_mk && (w_code == SC_ENTER);
      r_key_pause <= w_code_valid && !w_is_ext && w_mk && (w_code == SC_ESC);
    end
  end

`ifdef ARROW_KEYS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_al <= 1'b0;
      r_ar <= 1'b0;
      r_aj <= 1'b0;
    end else begin
      r_al <= w_al;
      r_ar <= w_ar;
      r_aj <= w_aj;
    end
  end
`endif

  assign stepleft  = r_stepleft;
  assign stepright = r_stepright;
  assign stepjump  = r_stepjump;
  assign key_start = r_key_start;
  assign key_pause = r_key_pause;

endmodule

// File: tb/tb_char_input_decoder.sv
// Bench for char_input_decoder: directed key scenarios then random key events
// checked against a key-event level model of held keys and press order.
module tb_char_input_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] ga;
  logic       stepleft, stepright, stepjump, key_start, key_pause;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Short timeout (20 cycles) keeps the prefix-timeout scenario cheap.
  char_input_decoder #(.CLK_HZ(1_000_000), .PREFIX_TIMEOUT_US(20)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .game_active(ga), .stepleft(stepleft), .stepright(stepright),
    .stepjump(stepjump), .key_start(key_start), .key_pause(key_pause)
  );

  // Model: which physical keys are down, and whether the latest direction
  // press was a right-hand key.
  bit mA, mD, mW, mSp, mAl, mAr, mAj, mLastR;
  bit eStart, ePause;

  function automatic bit arrows_on();
`ifdef ARROW_KEYS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit e_l();
    bit L = mA | mAl;
    bit R = mD | mAr;
    return (ga == 2'd1) && L && (!R || !mLastR);
  endfunction
  function automatic bit e_r();
    bit L = mA | mAl;
    bit R = mD | mAr;
    return (ga == 2'd1) && R && (!L || mLastR);
  endfunction
  function automatic bit e_j();
    return (ga == 2'd1) && (mW | mSp | mAj);
  endfunction

  task automatic model_reset();
    {mA, mD, mW, mSp, mAl, mAr, mAj, mLastR} = '0;
  endtask

  task automatic model_apply(input bit ext, input bit brk, input logic [7:0] c);
    eStart = !ext && !brk && c == 8'h5A;
    ePause = !ext && !brk && c == 8'h76;
    if (!ext) begin
      if (c == 8'h1C) begin mA = !brk; if (!brk) mLastR = 0; end
      if (c == 8'h23) begin mD = !brk; if (!brk) mLastR = 1; end
      if (c == 8'h1D) mW  = !brk;
      if (c == 8'h29) mSp = !brk;
    end else if (arrows_on()) begin
      if (c == 8'h6B) begin mAl = !brk; if (!brk) mLastR = 0; end
      if (c == 8'h74) begin mAr = !brk; if (!brk) mLastR = 1; end
      if (c == 8'h75) mAj = !brk;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit s, input bit p);
    chk({tag, ".stepleft"},  stepleft,  e_l());
    chk({tag, ".stepright"}, stepright, e_r());
    chk({tag, ".stepjump"},  stepjump,  e_j());
    chk({tag, ".key_start"}, key_start, s);
    chk({tag, ".key_pause"}, key_pause, p);
  endtask

  // Sends n back-to-back bytes; outputs must not move on non-final bytes.
  task automatic raw(input int n, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2);
    logic [7:0] bb [3];
    bb[0] = b0; bb[1] = b1; bb[2] = b2;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) check_all("mid", 0, 0);
      rx_data  = bb[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic key(input string tag, input bit ext, input bit brk, input logic [7:0] c);
    if (ext && brk)  raw(3, 8'hE0, 8'hF0, c);
    else if (ext)    raw(2, 8'hE0, c, 8'h00);
    else if (brk)    raw(2, 8'hF0, c, 8'h00);
    else             raw(1, c, 8'h00, 8'h00);
    model_apply(ext, brk, c);
    check_all(tag, eStart, ePause);
    @(negedge clk);
    check_all({tag, ".after"}, 0, 0);
  endtask

  logic [7:0] codes [10];

  initial begin
    codes = '{8'h1C, 8'h23, 8'h1D, 8'h29, 8'h5A, 8'h76, 8'h15, 8'h6B, 8'h74, 8'h75};
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; ga = 2'd1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0);
    rst_n = 1'b1;

    key("a_make", 0, 0, 8'h1C);
    chk("a_make.direct", stepleft, 1'b1);
    key("a_break", 0, 1, 8'h1C);
    chk("a_break.direct", stepleft, 1'b0);

    key("lr_a", 0, 0, 8'h1C);
    key("lr_d", 0, 0, 8'h23);
    chk("lr_d.right", stepright, 1'b1);
    chk("lr_d.left", stepleft, 1'b0);
    key("lr_a_rep", 0, 0, 8'h1C);
    key("lr_d_rep", 0, 0, 8'h23);
    key("lr_d_brk", 0, 1, 8'h23);
    chk("lr_d_brk.left", stepleft, 1'b1);
    key("lr_a_brk", 0, 1, 8'h1C);

    key("j_w", 0, 0, 8'h1D);
    key("j_sp", 0, 0, 8'h29);
    key("j_w_brk", 0, 1, 8'h1D);
    chk("j_w_brk.jump", stepjump, 1'b1);
    key("j_sp_brk", 0, 1, 8'h29);
    chk("j_sp_brk.jump", stepjump, 1'b0);

    // Stalled break prefix: after the timeout the next 1C is a make.
    raw(1, 8'hF0, 8'h00, 8'h00);
    repeat (30) @(negedge clk);
    key("tmo_make", 0, 0, 8'h1C);
    chk("tmo_make.left", stepleft, 1'b1);
    // Short gap stays inside the window, so 1C completes a break.
    raw(1, 8'hF0, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    raw(1, 8'h1C, 8'h00, 8'h00);
    mA = 0;
    check_all("short_gap", 0, 0);

    key("gate_d", 0, 0, 8'h23);
    ga = 2'd0;
    @(negedge clk);
    check_all("gate_off", 0, 0);
    chk("gate_off.right", stepright, 1'b0);
    key("gate_start", 0, 0, 8'h5A);
    chk("gate_start.pulse", key_start, 1'b0);
    ga = 2'd1;
    @(negedge clk);
    check_all("gate_on", 0, 0);
    chk("gate_on.right", stepright, 1'b1);
    key("start", 0, 0, 8'h5A);
    key("pause", 0, 0, 8'h76);
    key("gate_d_brk", 0, 1, 8'h23);

    key("arrow_l", 1, 0, 8'h6B);
    chk("arrow_l.left", stepleft, arrows_on());
    key("arrow_l_brk", 1, 1, 8'h6B);
    key("ext_a", 1, 0, 8'h1C);
    key("ext_enter", 1, 0, 8'h5A);

    // E0 E0 1C is still one extended code; F0 E0 is dropped with no effect.
    raw(3, 8'hE0, 8'hE0, 8'h1C);
    check_all("ext_ext", 0, 0);
    raw(2, 8'hF0, 8'hE0, 8'h00);
    check_all("brk_pfx", 0, 0);
    key("after_brk_pfx", 0, 0, 8'h1C);

    // Reset mid-sequence drops the partial break and all held keys.
    raw(1, 8'hF0, 8'h00, 8'h00);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("mid_reset", 0, 0);
    rst_n = 1'b1;
    key("post_reset", 0, 0, 8'h1C);
    chk("post_reset.left", stepleft, 1'b1);

    for (int i = 0; i < 400; i++) begin
      int k;
      bit ext;
      k   = $urandom_range(0, 9);
      ext = (k >= 7) ? 1'b1 : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) begin
        ga = 2'($urandom_range(0, 3));
        @(negedge clk);
        check_all("rnd_ga", 0, 0);
      end
      key("rnd", ext, $urandom_range(0, 1) == 1, codes[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/char_input_decoder.md
# char_input_decoder

Converts the PS/2 set-2 scan-code byte stream into the held-key level signals `stepleft`, `stepright` and `stepjump`, which drive the character controller. It also produces start/pause strobes for the game-state logic. It sits between the PS/2 byte receiver and the character controller, and runs in the 65 MHz pixel clock domain.

## Interface
Parameters:
- `CLK_HZ`, 65_000_000: clock frequency in Hz, used to size the timeout.
- `PREFIX_TIMEOUT_US`, 2000: after a prefix byte (E0/F0), the decoder abandons the sequence if no further byte arrives within this many µs.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received scan-code byte; valid only while `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `game_active`  in  2  game state; 1 means gameplay.
- `stepleft`  out  1  move-left held level.
- `stepright`  out  1  move-right held level.
- `stepjump`  out  1  jump key held level.
- `key_start`  out  1  one-cycle pulse on an Enter make code.
- `key_pause`  out  1  one-cycle pulse on an Esc make code.

## Operation
- Byte FSM states are IDLE, EXT, BRK and EXT_BRK.
  - IDLE: E0→EXT; F0→BRK; any other byte is a make code and returns to IDLE.
  - EXT: F0→EXT_BRK; E0 stays in EXT; any other byte is an extended make code and returns to IDLE.
  - BRK: any byte other than E0/F0 is a break code and returns to IDLE; E0/F0 in BRK returns to IDLE with no key effect.
  - EXT_BRK: any byte is an extended break code and returns to IDLE.
- Timeout: in any non-IDLE state, if no `rx_valid` arrives within `PREFIX_TIMEOUT_US`, the FSM returns to IDLE. Held-key flags are not changed.
- Key map: A (1C) is left, D (23) is right, W (1D) is jump, Space (29) is jump, Enter (5A) is start, Esc (76) is pause. Only non-extended codes map.
- Held flags: `held_l`, `held_r` and `held_j`. Make sets the flag and break clears it. Because two keys map to jump, `held_j` is the OR of the W flag and the Space flag, each tracked separately. Typematic repeats of a make code are idempotent.
- Left/right arbitration: a `last_dir` register records the most recently made direction key.
  - If both keys are held, only the `last_dir` output is 1.
  - If only one key is held, that one wins.
  - On release of the winning key, the output switches to the other key if it is still held.
- Gating: when `game_active`≠1, all step outputs are 0. Flags keep tracking so that held keys resume when play resumes.
- Strobes: `key_start`/`key_pause` fire on make codes only; repeats re-fire. They are not gated by `game_active`.
- Unmapped codes change the FSM state but have no other effect.

## Timing
- All outputs are registered.
- Latency: the step outputs update on the clock edge after the `rx_valid` that carries the final byte of a sequence, so the response appears 1 cycle after that strobe.
- Strobes are exactly one cycle wide, asserted 1 cycle after the final byte.
- Reset values: all outputs 0, FSM in IDLE, flags cleared, `last_dir`=left, timeout counter 0.
- Reset mid-sequence discards the partial sequence.
- `rx_valid` may be asserted on consecutive cycles; every byte is consumed with no stall.
- Timeout counter width is `$clog2(CLK_HZ/1_000_000*PREFIX_TIMEOUT_US+1)`. It is cleared on every `rx_valid` and saturates at the limit.

## Configuration
- `ARROW_KEYS_EN` defined:
  - Extended E0 6B is left, E0 74 is right, E0 75 is jump.
  - Each arrow key has its own flag, ORed with the matching letter-key flag.
  - Arbitration treats an arrow make as a direction make.
- `ARROW_KEYS_EN` undefined: all extended codes are parsed and ignored, and the arrow flags are not synthesized.

## Structure
- Scan-code constants (A, D, W, SPACE, ENTER, ESC, arrows, PREFIX_EXT=E0, PREFIX_BRK=F0) and the FSM state enum `kbd_state_t` live in the shared `game_pkg`.
- Sub-module `kbd_scan_fsm` contains the byte FSM and timeout. It outputs `code_valid` (one cycle), `code`[7:0], `is_ext` and `is_break`.
- The top level holds the flags, arbitration, gating and strobes.

## Test plan
- 1C with `game_active`=1 → `stepleft`=1 next cycle. Then F0,1C → `stepleft`=0 one cycle after the 1C strobe.
- 1C, then 23 (both held) → `stepright`=1 and `stepleft`=0. Then F0,23 → `stepleft`=1 again.
- 1D and 29 made, then F0,1D → `stepjump` stays 1. Then F0,29 → `stepjump`=0.
- F0 followed by no byte for 2000 µs, then 1C → the timeout resets the FSM to IDLE, so 1C is treated as a make and `stepleft`=1.
- With 23 held and `game_active`=0 → `stepright`=0. Set `game_active`=1 → `stepright`=1 next cycle. 5A → `key_start` pulse exactly 1 cycle wide.
- With `ARROW_KEYS_EN` defined, E0,6B → `stepleft`=1 and E0,F0,6B → 0. With the macro undefined, E0,6B → all step outputs stay 0.
